// File: rtl/compress_dispatch.sv
// Routes FIFO beats into a bypass stream or a compression-engine stream, one beat per cycle,
// tracking packet framing (header run, eligibility flag) and keeping saturating statistics.
module compress_dispatch #(
    parameter int BURST_WIDTH = 256,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   fifo_empty,
    input  logic [BURST_WIDTH-1:0] fifo_data,
    input  logic                   fifo_is_header,
    input  logic                   fifo_flag,
    input  logic                   fifo_last,
    output logic                   fifo_pop,
    output logic [BURST_WIDTH-1:0] byp_tdata,
    output logic                   byp_tlast,
    output logic                   byp_tvalid,
    input  logic                   byp_tready,
    output logic [BURST_WIDTH-1:0] cmp_tdata,
    output logic                   cmp_tlast,
    output logic                   cmp_tvalid,
    input  logic                   cmp_tready,
    output logic [CNT_WIDTH-1:0]   pkt_count,
    output logic [CNT_WIDTH-1:0]   cmp_beat_count,
    output logic [CNT_WIDTH-1:0]   trunc_count,
    output logic [1:0]             dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        CMP  = 2'd2,
        BYP  = 2'd3
    } state_t;

    state_t                 state, state_nxt;
    logic                   flag_q, flag_nxt;
    logic                   valid_q;
    logic                   dst_cmp_q;
    logic                   last_q;
    logic [BURST_WIDTH-1:0] data_q;
    logic                   accepted;
    logic                   route_cmp;
    logic                   is_trunc;

    // Handshake: a beat transfers when the selected stream's tvalid and tready are both high
    // on a rising edge; tvalid, tdata and tlast stay put until that transfer happens.
    assign accepted = valid_q & (dst_cmp_q ? cmp_tready : byp_tready);
    assign fifo_pop = !reset & !fifo_empty & (!valid_q | accepted);

    assign byp_tvalid = valid_q & !dst_cmp_q;
    assign cmp_tvalid = valid_q & dst_cmp_q;
    assign byp_tdata  = data_q;
    assign cmp_tdata  = data_q;
    assign byp_tlast  = last_q;
    assign cmp_tlast  = last_q;
    assign dbg_state  = state;

    always_comb begin
        state_nxt = state;
        flag_nxt  = flag_q;
        route_cmp = 1'b0;
        if (fifo_pop) begin
            case (state)
                IDLE: begin
                    flag_nxt  = fifo_is_header & fifo_flag;
                    state_nxt = fifo_is_header ? HDR : BYP;
                end
                HDR: begin
                    if (!fifo_is_header) begin
                        route_cmp = flag_q;
                        state_nxt = flag_q ? CMP : BYP;
                    end
                end
                CMP:     route_cmp = 1'b1;
                default: route_cmp = 1'b0;
            endcase
            if (fifo_last) state_nxt = IDLE;
        end
    end

    // A packet ending while still inside its header run counts as truncated.
    assign is_trunc = fifo_pop & fifo_last &
                      ((state == HDR) | ((state == IDLE) & fifo_is_header));

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v,
                                                     input logic en);
        return (en && (v != '1)) ? v + 1'b1 : v;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            flag_q         <= 1'b0;
            valid_q        <= 1'b0;
            dst_cmp_q      <= 1'b0;
            pkt_count      <= '0;
            cmp_beat_count <= '0;
            trunc_count    <= '0;
        end else begin
            state  <= state_nxt;
            flag_q <= flag_nxt;
            if (fifo_pop) begin
                valid_q   <= 1'b1;
                dst_cmp_q <= route_cmp;
            end else if (accepted) begin
                valid_q <= 1'b0;
            end
            pkt_count      <= sat_inc(pkt_count, fifo_pop & fifo_last);
            cmp_beat_count <= sat_inc(cmp_beat_count, fifo_pop & route_cmp);
            trunc_count    <= sat_inc(trunc_count, is_trunc);
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_pop) begin
            data_q <= fifo_data;
            last_q <= fifo_last;
        end
    end

endmodule

// File: tb/tb_compress_dispatch.sv
// Bench for compress_dispatch: a modelled input FIFO, packet-level routing model with
// per-stream expected queues, directed framing scenarios and a randomized packet run.
module tb_compress_dispatch;

    localparam int W  = 64;
    localparam int CW = 4;
    localparam int SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          fifo_empty;
    logic [W-1:0]  fifo_data;
    logic          fifo_is_header, fifo_flag, fifo_last, fifo_pop;
    logic [W-1:0]  byp_tdata, cmp_tdata;
    logic          byp_tlast, byp_tvalid, cmp_tlast, cmp_tvalid;
    logic          byp_tready = 1'b1;
    logic          cmp_tready = 1'b1;
    logic [CW-1:0] pkt_count, cmp_beat_count, trunc_count;
    logic [1:0]    dbg_state;

    compress_dispatch #(.BURST_WIDTH(W), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_is_header(fifo_is_header), .fifo_flag(fifo_flag), .fifo_last(fifo_last),
        .fifo_pop(fifo_pop),
        .byp_tdata(byp_tdata), .byp_tlast(byp_tlast), .byp_tvalid(byp_tvalid),
        .byp_tready(byp_tready),
        .cmp_tdata(cmp_tdata), .cmp_tlast(cmp_tlast), .cmp_tvalid(cmp_tvalid),
        .cmp_tready(cmp_tready),
        .pkt_count(pkt_count), .cmp_beat_count(cmp_beat_count), .trunc_count(trunc_count),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Input FIFO model: written by the stimulus, popped by the DUT.
    logic [W-1:0] mem_data [4096];
    logic         mem_hdr  [4096];
    logic         mem_flag [4096];
    logic         mem_last [4096];
    logic [11:0]  wr_ptr = '0;
    logic [11:0]  rd_ptr = '0;
    logic         flush = 1'b0;

    assign fifo_empty     = (rd_ptr == wr_ptr);
    assign fifo_data      = mem_data[rd_ptr];
    assign fifo_is_header = mem_hdr[rd_ptr];
    assign fifo_flag      = mem_flag[rd_ptr];
    assign fifo_last      = mem_last[rd_ptr];

    always @(posedge clk) begin
        if (flush) rd_ptr <= wr_ptr;
        else if (fifo_pop) rd_ptr <= rd_ptr + 12'd1;
    end

    // Scoreboard state
    logic [W:0] byp_q[$];
    logic [W:0] cmp_q[$];
    int m_pkt = 0, m_cmp = 0, m_trunc = 0;
    int total = 0, passed = 0;
    int byp_acc = 0, cmp_acc = 0, cmp_vcyc = 0;

    task automatic check(input string tag, input logic [W:0] obs, input logic [W:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    endtask

    function automatic int sat(input int v);
        return (v > SAT) ? SAT : v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_beat(input logic hdr, input logic flag, input logic last,
                             input bit to_cmp);
        logic [W-1:0] d;
        d = {$urandom, $urandom};
        mem_data[wr_ptr] = d;
        mem_hdr[wr_ptr]  = hdr;
        mem_flag[wr_ptr] = flag;
        mem_last[wr_ptr] = last;
        wr_ptr = wr_ptr + 12'd1;
        if (to_cmp) begin
            cmp_q.push_back({last, d});
            m_cmp++;
        end else begin
            byp_q.push_back({last, d});
        end
    endtask

    // Packet of n beats whose first `lead` beats are headers; payload goes to cmp only when
    // the packet opens with a header whose flag is set. Later header/flag bits are noise.
    task automatic push_pkt(input int n, input int lead, input logic flag0, input bit rnd);
        for (int i = 0; i < n; i++) begin
            logic hdr, flag;
            hdr  = (i < lead) ? 1'b1 : ((i == lead) ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b0));
            flag = (i == 0) ? flag0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b0);
            push_beat(hdr, flag, i == n - 1, (lead > 0) && flag0 && (i >= lead));
        end
        m_pkt++;
        if (lead > 0 && lead >= n - 1) m_trunc++;
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_pkt_count"}, (W+1)'(pkt_count), (W+1)'(sat(m_pkt)));
        check({tag, "_cmp_beat_count"}, (W+1)'(cmp_beat_count), (W+1)'(sat(m_cmp)));
        check({tag, "_trunc_count"}, (W+1)'(trunc_count), (W+1)'(sat(m_trunc)));
        check({tag, "_state_idle"}, (W+1)'(dbg_state), '0);
    endtask

    task automatic drain(input bit rnd);
        int k;
        k = 0;
        while (k < 3000 && !(fifo_empty && byp_q.size() == 0 && cmp_q.size() == 0 &&
                             !byp_tvalid && !cmp_tvalid)) begin
            if (rnd) begin
                byp_tready = ($urandom_range(0, 3) != 0);
                cmp_tready = ($urandom_range(0, 3) != 0);
            end
            tick();
            k++;
        end
        byp_tready = 1'b1;
        cmp_tready = 1'b1;
        check("drain_done", (W+1)'(k < 3000), 1);
    endtask

    task automatic clear_model();
        byp_q.delete();
        cmp_q.delete();
        m_pkt = 0;
        m_cmp = 0;
        m_trunc = 0;
    endtask

    // Stream monitor: in-order beat checks, stall stability and no-pop-while-stalled.
    logic       byp_hold = 1'b0, cmp_hold = 1'b0;
    logic [W:0] byp_held, cmp_held;

    always @(negedge clk) begin
        if (reset) begin
            byp_hold = 1'b0;
            cmp_hold = 1'b0;
        end else begin
            if (byp_hold) begin
                check("byp_stall_valid", (W+1)'(byp_tvalid), 1);
                check("byp_stall_data", {byp_tlast, byp_tdata}, byp_held);
            end
            if (cmp_hold) begin
                check("cmp_stall_valid", (W+1)'(cmp_tvalid), 1);
                check("cmp_stall_data", {cmp_tlast, cmp_tdata}, cmp_held);
            end
            if (byp_tvalid && byp_tready) begin
                byp_acc++;
                check("byp_beat_expected", (W+1)'(byp_q.size() != 0), 1);
                if (byp_q.size() != 0) check("byp_beat", {byp_tlast, byp_tdata}, byp_q.pop_front());
            end
            if (cmp_tvalid && cmp_tready) begin
                cmp_acc++;
                check("cmp_beat_expected", (W+1)'(cmp_q.size() != 0), 1);
                if (cmp_q.size() != 0) check("cmp_beat", {cmp_tlast, cmp_tdata}, cmp_q.pop_front());
            end
            if (cmp_tvalid) cmp_vcyc++;
            if ((byp_tvalid && !byp_tready) || (cmp_tvalid && !cmp_tready))
                check("stall_no_pop", (W+1)'(fifo_pop), 0);
            byp_hold = byp_tvalid && !byp_tready;
            cmp_hold = cmp_tvalid && !cmp_tready;
            byp_held = {byp_tlast, byp_tdata};
            cmp_held = {cmp_tlast, cmp_tdata};
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, a0, b0, c0, v0;
        logic [W:0] held;

        // Reset with a beat waiting: nothing may pop, outputs idle
        flush = 1'b1;
        push_beat(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (3) tick();
        check("rst_byp_tvalid", (W+1)'(byp_tvalid), 0);
        check("rst_cmp_tvalid", (W+1)'(cmp_tvalid), 0);
        check("rst_fifo_pop", (W+1)'(fifo_pop), 0);
        check_counters("rst");
        reset = 1'b0;
        flush = 1'b0;
        clear_model();
        tick();

        // Eligible packet at full rate
        a0 = byp_acc; c0 = cmp_acc;
        push_pkt(7, 4, 1'b1, 1'b0);
        repeat (8) tick();
        check("elig_byp_beats", (W+1)'(byp_acc - a0), 4);
        check("elig_cmp_beats", (W+1)'(cmp_acc - c0), 3);
        drain(1'b0);
        check_counters("elig");

        // Ineligible packet: everything bypasses
        a0 = byp_acc; v0 = cmp_vcyc;
        push_pkt(7, 4, 1'b0, 1'b0);
        drain(1'b0);
        check("inelig_byp_beats", (W+1)'(byp_acc - a0), 7);
        check("inelig_cmp_valid", (W+1)'(cmp_vcyc - v0), 0);
        check_counters("inelig");

        // Backpressure on cmp mid-payload
        push_pkt(7, 4, 1'b1, 1'b0);
        k = 0;
        while (!cmp_tvalid && k < 50) begin tick(); k++; end
        check("bp_reach_payload", (W+1)'(k < 50), 1);
        tick();
        cmp_tready = 1'b0;
        held = {cmp_tlast, cmp_tdata};
        repeat (5) begin
            tick();
            check("bp_hold_valid", (W+1)'(cmp_tvalid), 1);
            check("bp_hold_data", {cmp_tlast, cmp_tdata}, held);
            check("bp_no_pop", (W+1)'(fifo_pop), 0);
        end
        cmp_tready = 1'b1;
        drain(1'b0);
        check_counters("bp");

        // Truncated header, then a normal eligible packet
        push_pkt(2, 2, 1'b1, 1'b0);
        push_pkt(7, 4, 1'b1, 1'b0);
        drain(1'b0);
        check_counters("trunc");

        // One-beat non-header packet back to back with an eligible packet
        a0 = byp_acc; c0 = cmp_acc;
        push_pkt(1, 0, 1'b0, 1'b0);
        push_pkt(7, 4, 1'b1, 1'b0);
        repeat (9) tick();
        check("b2b_no_bubble", (W+1)'(byp_acc + cmp_acc - a0 - c0), 8);
        drain(1'b0);
        check_counters("b2b");

        // Reset while a payload beat is held on cmp
        cmp_tready = 1'b0;
        push_pkt(7, 4, 1'b1, 1'b0);
        k = 0;
        while (!cmp_tvalid && k < 50) begin tick(); k++; end
        check("mid_rst_reach_payload", (W+1)'(k < 50), 1);
        reset = 1'b1;
        flush = 1'b1;
        tick();
        reset = 1'b0;
        flush = 1'b0;
        clear_model();
        check("mid_rst_byp_tvalid", (W+1)'(byp_tvalid), 0);
        check("mid_rst_cmp_tvalid", (W+1)'(cmp_tvalid), 0);
        check_counters("mid_rst");
        cmp_tready = 1'b1;
        push_pkt(7, 4, 1'b1, 1'b0);
        drain(1'b0);
        check_counters("post_rst");

        // Randomized packets with random readiness; counters run into saturation
        for (int p = 0; p < 150; p++) begin
            int n;
            n = $urandom_range(1, 8);
            push_pkt(n, $urandom_range(0, n), 1'($urandom_range(0, 1)), 1'b1);
            repeat ($urandom_range(0, 4)) begin
                byp_tready = ($urandom_range(0, 3) != 0);
                cmp_tready = ($urandom_range(0, 3) != 0);
                tick();
            end
        end
        drain(1'b1);
        check_counters("random");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
